layer2_argmax_seq: RTL and testbench
====================================

LAYER2_ARGMAX_SEQ -- requirements
Module: layer2_argmax_seq

Interface
REQ-001 Parameter N_CLASS, default 10, number of logits per frame; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 29, width of each logit, two's complement.
REQ-003 Parameter IDX_WIDTH, default 4, width of the class index; SHALL satisfy 2^IDX_WIDTH >= N_CLASS.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  logit frame on layer_in is valid.
REQ-007 in_ready  output  1  block can accept a frame.
REQ-008 layer_in  input  N_CLASS*DATA_WIDTH  packed logits; logit k occupies bits [k*DATA_WIDTH +: DATA_WIDTH], with logit 0 in the LSBs.
REQ-009 class_out  output  IDX_WIDTH  index of the maximum logit.
REQ-010 max_out  output  DATA_WIDTH  value of the maximum logit.
REQ-011 out_valid  output  1  class_out and max_out are valid.
REQ-012 out_ready  input  1  downstream accepts the result.

Function
REQ-013 FSM states: IDLE, SCAN, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE.
  - in_ready SHALL be a registered function of state, not combinational from in_valid.
REQ-015 Frame acceptance occurs on an edge where in_valid=1 and in_ready=1. At that edge:
  - all N_CLASS logits are captured into an internal frame register;
  - best value is set to logit 0 and best index to 0;
  - the scan counter is set to 1;
  - state goes to SCAN.
REQ-016 layer_in SHALL be sampled only at the acceptance edge; later changes SHALL NOT affect the result.
REQ-017 In SCAN, each edge compares captured logit[counter] with the best value, then increments counter.
  - Compare rule: if logit[counter] > best (signed, strictly greater), best value and best index are updated.
REQ-018 Ties SHALL keep the earlier (lower) index.
REQ-019 On the edge that compares logit N_CLASS-1:
  - the final best value and best index are loaded into max_out and class_out;
  - out_valid is set to 1;
  - state goes to DONE.
REQ-020 Latency: out_valid SHALL rise exactly N_CLASS-1 clocks after the acceptance edge (9 for the default).
REQ-021 In DONE, out_valid, class_out and max_out SHALL be held stable until an edge with out_ready=1.
  - At that edge: out_valid becomes 0, state goes to IDLE, and in_ready becomes 1 on the following cycle.
REQ-022 class_out and max_out SHALL retain their last values after the handshake, until the next result is loaded.
REQ-023 in_valid asserted while in_ready=0 (SCAN or DONE) SHALL be ignored, with no capture and no queuing.
REQ-024 Minimum frame period is N_CLASS+1 clocks when out_ready is held high.
REQ-025 All comparisons SHALL be full-width DATA_WIDTH signed comparisons with no saturation or truncation.
  - Logits carry wrapped upstream arithmetic and are interpreted as two's complement.
REQ-026 The scan counter SHALL NOT exceed N_CLASS-1; no out-of-range frame index is ever read.

Reset
REQ-027 While rst=1 at an edge:
  - state goes to IDLE;
  - out_valid=0, class_out=0, max_out=0, in_ready=1 (visible after the edge);
  - the scan counter, best value and best index are cleared.
REQ-028 Reset in SCAN or DONE SHALL discard the frame in progress; no out_valid is produced for it.
REQ-029 rst takes priority over simultaneous in_valid or out_ready.

Verification
REQ-030 All logits 0 except logit 7 = 100, out_ready=1 -> class_out=7, max_out=100; out_valid rises 9 clocks after acceptance and stays high 1 cycle.
REQ-031 All logits -5 (0x1FFFFFFB) except logit 3 = -1 -> class_out=3, max_out=0x1FFFFFFF.
REQ-032 Logits 2 and 6 both 500, all others 499 -> class_out=2 (tie keeps the lower index).
REQ-033 Logit 0 = 0x10000000 (most negative), logit 9 = 0x0FFFFFFF, others 0 -> class_out=9, max_out=0x0FFFFFFF; checks signed rather than unsigned compare.
REQ-034 out_ready held 0 for 5 cycles after out_valid rises, with a second in_valid pulsed meanwhile:
  - outputs hold stable and in_ready stays 0;
  - the second frame is ignored;
  - after out_ready=1 the block returns to IDLE and the next frame gives a fresh correct result.
REQ-035 rst asserted 1 cycle during the 4th SCAN cycle -> after that edge out_valid=0, in_ready=1, class_out=0, max_out=0; no result is emitted for that frame.

Source files
------------

// File: rtl/layer2_argmax_seq.sv
`default_nettype none
// ============================================================================
// Module      : layer2_argmax_seq
// Description : Sequential argmax over one frame of signed logits, one
//               compare per clock, with a valid/ready result handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module layer2_argmax_seq #(
    parameter int N_CLASS    = 10,
    parameter int DATA_WIDTH = 29,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_CLASS*DATA_WIDTH-1:0] layer_in,
    output logic [IDX_WIDTH-1:0]          class_out,
    output logic [DATA_WIDTH-1:0]         max_out,
    output logic                          out_valid,
    input  logic                          out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] C_LAST_IDX = IDX_WIDTH'(N_CLASS - 1);

    state_t                        r_state;
    state_t                        w_next_state;
    logic signed [DATA_WIDTH-1:0]  r_logit [N_CLASS];
    logic [IDX_WIDTH-1:0]          r_cnt;
    logic signed [DATA_WIDTH-1:0]  r_best_val;
    logic [IDX_WIDTH-1:0]          r_best_idx;
    logic [IDX_WIDTH-1:0]          r_class_out;
    logic [DATA_WIDTH-1:0]         r_max_out;
    logic                          r_out_valid;
    logic                          r_in_ready;
    logic signed [DATA_WIDTH-1:0]  w_cur;
    logic                          w_accept;
    logic                          w_gt;
    logic                          w_last;

    assign w_accept = r_in_ready & in_valid;
    assign w_last   = (r_cnt == C_LAST_IDX);
    // Strictly greater, so ties keep the earlier (lower) index.
    assign w_gt     = (w_cur > r_best_val);

    always_comb begin
        w_cur = '0;
        for (int k = 0; k < N_CLASS; k++) begin
            if (r_cnt == IDX_WIDTH'(k)) begin
                w_cur = r_logit[k];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_next_state = SCAN;
            SCAN:    if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == IDLE);
        end
    end

    // Frame storage is only loaded at acceptance, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            for (int k = 0; k < N_CLASS; k++) begin
                r_logit[k] <= layer_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_class_out <= '0;
            r_max_out   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_best_val <= layer_in[DATA_WIDTH-1:0];
                        r_best_idx <= '0;
                        r_cnt      <= IDX_WIDTH'(1);
                    end
                end
                SCAN: begin
                    if (w_gt) begin
                        r_best_val <= w_cur;
                        r_best_idx <= r_cnt;
                    end
                    if (w_last) begin
                        r_class_out <= w_gt ? r_cnt : r_best_idx;
                        r_max_out   <= w_gt ? w_cur : r_best_val;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign class_out = r_class_out;
    assign max_out   = r_max_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_layer2_argmax_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer2_argmax_seq
// Description : Directed self-checking bench for layer2_argmax_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer2_argmax_seq;

    localparam int N = 10;
    localparam int W = 29;
    localparam int I = 4;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] layer_in;
    logic [I-1:0]   class_out;
    logic [W-1:0]   max_out;
    logic           out_valid;
    logic           out_ready;

    int total = 0;
    int bad   = 0;

    layer2_argmax_seq #(
        .N_CLASS    (N),
        .DATA_WIDTH (W),
        .IDX_WIDTH  (I)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .layer_in  (layer_in),
        .class_out (class_out),
        .max_out   (max_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All logits = base, then overrides at i1 and i2 (skip an override with -1).
    function automatic logic [N*W-1:0] mk(input logic [W-1:0] base,
                                          input int i1, input logic [W-1:0] v1,
                                          input int i2, input logic [W-1:0] v2);
        logic [N*W-1:0] f;
        for (int k = 0; k < N; k++) f[k*W +: W] = base;
        if (i1 >= 0) f[i1*W +: W] = v1;
        if (i2 >= 0) f[i2*W +: W] = v2;
        return f;
    endfunction

    // Accepts one frame and checks latency and result. With hold set, returns
    // right after out_valid rises so the caller can exercise backpressure.
    task automatic run_frame(input string tag, input logic [N*W-1:0] frame,
                             input logic [I-1:0] exp_cls, input logic [W-1:0] exp_max,
                             input bit hold);
        int n;
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        layer_in = frame;
        tick();
        in_valid = 1'b0;
        // Late input changes must not affect the result.
        layer_in = mk(29'h0FFFFFFF, -1, '0, -1, '0);
        chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(N - 1));
        chk({tag, "_class"}, 32'(class_out), 32'(exp_cls));
        chk({tag, "_max"}, 32'(max_out), 32'(exp_max));
        if (!hold) begin
            tick();
            chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
            chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
            chk({tag, "_class_keep"}, 32'(class_out), 32'(exp_cls));
        end
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        layer_in  = '0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_class", 32'(class_out), 32'd0);
        chk("rst_max", 32'(max_out), 32'd0);
        rst = 1'b0;
        tick();

        run_frame("single_peak", mk('0, 7, 29'd100, -1, '0), 4'd7, 29'd100, 1'b0);
        run_frame("neg_peak", mk(29'h1FFFFFFB, 3, 29'h1FFFFFFF, -1, '0),
                  4'd3, 29'h1FFFFFFF, 1'b0);
        run_frame("tie_low", mk(29'd499, 2, 29'd500, 6, 29'd500), 4'd2, 29'd500, 1'b0);
        run_frame("signed_cmp", mk('0, 0, 29'h10000000, 9, 29'h0FFFFFFF),
                  4'd9, 29'h0FFFFFFF, 1'b0);

        // Backpressure with an extra frame offered while busy.
        out_ready = 1'b0;
        run_frame("hold", mk(29'd10, 4, 29'd20, -1, '0), 4'd4, 29'd20, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 1);
            if (i == 1) layer_in = mk('0, 8, 29'd777, -1, '0);
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_class", 32'(class_out), 32'd4);
            chk("hold_max", 32'(max_out), 32'd20);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("hold_release_valid", 32'(out_valid), 32'd0);
        chk("hold_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("ignored_frame_ready", 32'(in_ready), 32'd1);
        chk("ignored_frame_valid", 32'(out_valid), 32'd0);
        run_frame("after_hold", mk(29'd1, 1, 29'd3, 5, 29'd2), 4'd1, 29'd3, 1'b0);

        // Reset on the fourth scan edge discards the frame.
        in_valid = 1'b1;
        layer_in = mk('0, 5, 29'd55, -1, '0);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_class", 32'(class_out), 32'd0);
        chk("mid_rst_max", 32'(max_out), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);
        run_frame("after_rst", mk(29'h1FFFFF00, 9, 29'h1FFFFF01, -1, '0),
                  4'd9, 29'h1FFFFF01, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
